br_sequencer: RTL

BR_SEQUENCER -- requirements
Module: br_sequencer

---
 rtl/br_pkg.sv | 31 +++
 rtl/br_decode.sv | 30 +++
 rtl/br_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/br_pkg.sv
// Shared definitions for the branch sequencer and the next-PC selector:
// status codes, instruction field constants and sequencer state encoding.
package br_pkg;

    typedef enum logic [2:0] {
        ST_SEQ   = 3'b000,
        ST_BMN   = 3'b001,
        ST_BRZ   = 3'b010,
        ST_BZ    = 3'b011,
        ST_JMOR  = 3'b100,
        ST_JALM  = 3'b101,
        ST_JSPAL = 3'b110
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PUSH  = 2'd1,
        S_FETCH = 2'd2,
        S_ISSUE = 2'd3
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BZ    = 6'h16;
    localparam logic [5:0] OP_BMN   = 6'h17;

    localparam logic [5:0] FN_BRZ   = 6'h12;
    localparam logic [5:0] FN_JMOR  = 6'h13;
    localparam logic [5:0] FN_JALM  = 6'h14;
    localparam logic [5:0] FN_JSPAL = 6'h15;

endpackage

// File: rtl/br_decode.sv
// Combinational decode of opcode/funct into the branch status class.
module br_decode
    import br_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output status_e    code,
    output logic       is_branch
);

    always_comb begin
        code = ST_SEQ;
        case (opcode)
            OP_BZ:    code = ST_BZ;
            OP_BMN:   code = ST_BMN;
            OP_RTYPE: begin
                case (funct)
                    FN_BRZ:   code = ST_BRZ;
                    FN_JMOR:  code = ST_JMOR;
                    FN_JALM:  code = ST_JALM;
                    FN_JSPAL: code = ST_JSPAL;
                    default:  code = ST_SEQ;
                endcase
            end
            default:  code = ST_SEQ;
        endcase
        is_branch = (code != ST_SEQ);
    end

endmodule

// File: rtl/br_sequencer.sv
// Branch sequencer: decodes branch/jump instructions, performs the optional
// stack push and memory target fetch, then issues a one-cycle next-PC select.
module br_sequencer
    import br_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int SP_STEP     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_val,
    input  logic [31:0] sp_val,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] j_diraddr,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic        alu_v,
    input  logic        flags_we,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  status,
    output logic        n,
    output logic        z,
    output logic        v,
    output logic [31:0] mem_out,
    output logic        br_valid,
    output logic        stall,
    output logic        link_we,
    output logic        sp_we,
    output logic        err,
    output logic [31:0] link_data,
    output logic [31:0] sp_next
);

    localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

    state_e      state, state_nx;
    status_e     dec_code, code_q;
    logic        dec_br;
    logic        timeout;
    logic        take;
    logic [7:0]  cnt;
    logic [31:0] pc_q, rs_q, sp_q;
    logic [31:0] sp_dec;

    // The direct jump target is consumed by the next-PC selector, not here.
    logic unused_diraddr;
    assign unused_diraddr = ^j_diraddr;

    br_decode u_decode (
        .opcode    (opcode),
        .funct     (funct),
        .code      (dec_code),
        .is_branch (dec_br)
    );

    assign take   = (state == S_IDLE) && instr_valid;
    assign sp_dec = sp_q - 32'(SP_STEP);

    always_comb begin
        state_nx  = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        stall     = 1'b0;
        br_valid  = 1'b0;
        status    = ST_SEQ;
        link_we   = 1'b0;
        link_data = '0;
        sp_we     = 1'b0;
        sp_next   = '0;
        timeout   = 1'b0;
        case (state)
            S_IDLE: begin
                stall = instr_valid && dec_br;
                if (instr_valid) begin
                    case (dec_code)
                        ST_BZ, ST_BRZ: state_nx = S_ISSUE;
                        ST_JSPAL:      state_nx = S_PUSH;
                        ST_SEQ:        state_nx = S_IDLE;
                        default:       state_nx = S_FETCH;
                    endcase
                end
            end
            S_PUSH: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp_dec;
                mem_wdata = pc_q;
                stall     = 1'b1;
                if (mem_ack) begin
                    state_nx = S_FETCH;
                end else if (cnt == CNT_LAST) begin
                    timeout  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = rs_q;
                stall    = 1'b1;
                if (mem_ack) begin
                    state_nx = S_ISSUE;
                end else if (cnt == CNT_LAST) begin
                    timeout  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_ISSUE: begin
                br_valid = 1'b1;
                status   = code_q;
                if (code_q == ST_JALM) begin
                    link_we   = 1'b1;
                    link_data = pc_q;
                end
                if (code_q == ST_JSPAL) begin
                    sp_we   = 1'b1;
                    sp_next = sp_dec;
                end
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            code_q  <= ST_SEQ;
            cnt     <= '0;
            err     <= 1'b0;
            n       <= 1'b0;
            z       <= 1'b0;
            v       <= 1'b0;
            mem_out <= '0;
        end else begin
            state <= state_nx;
            err   <= timeout;
            // Every state change starts a fresh per-access wait window.
            if (state_nx != state) begin
                cnt <= '0;
            end else if (mem_req) begin
                cnt <= cnt + 8'd1;
            end
            if (take) begin
                code_q <= dec_code;
            end
            if (flags_we) begin
                n <= alu_n;
                z <= alu_z;
                v <= alu_v;
            end
            if (state == S_FETCH && mem_ack) begin
                mem_out <= mem_rdata;
            end
        end
    end

    // Operands captured at decode so later changes upstream do not disturb the sequence.
    always_ff @(posedge clk) begin
        if (take) begin
            pc_q <= pc_plus4;
            rs_q <= rs_val;
            sp_q <= sp_val;
        end
    end

endmodule
